// File: rtl/sdlx_pkg.sv
// Shared SDLX constants and types: opcodes, functs, ALU ops, control states and decode classes.
package sdlx_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h04;
    localparam logic [5:0] FN_SRL = 6'h06;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R = 3'd0,
        CLS_ALU_I = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQZ  = 3'd4,
        CLS_BNEZ  = 3'd5,
        CLS_J     = 3'd6
    } iclass_t;

    // Classes that redirect or advance the PC directly from EXEC.
    function automatic logic is_branch(input iclass_t c);
        return (c == CLS_BEQZ) || (c == CLS_BNEZ) || (c == CLS_J);
    endfunction

endpackage

// File: rtl/sdlx_decode.sv
// Combinational instruction classifier: opcode/funct -> class, ALU function, legality.
module sdlx_decode
    import sdlx_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        cls    = CLS_ALU_R;
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_ALU_R;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI: begin cls = CLS_ALU_I; alu_op = ALU_ADD; end
            OP_SLTI: begin cls = CLS_ALU_I; alu_op = ALU_SLT; end
            OP_ANDI: begin cls = CLS_ALU_I; alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALU_I; alu_op = ALU_OR;  end
            OP_XORI: begin cls = CLS_ALU_I; alu_op = ALU_XOR; end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQZ: cls = CLS_BEQZ;
            OP_BNEZ: cls = CLS_BNEZ;
            OP_J:    cls = CLS_J;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sdlx_control.sv
// Multi-cycle SDLX control FSM: fetch/decode/exec/mem/wb sequencing and datapath selects.
// Optional SDLX_CTRL_PERF_EN adds cycle_cnt/instr_cnt performance counters.
module sdlx_control
    import sdlx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        rd_sel,
    output logic        oprnd1_sel,
    output logic        oprnd2_sel,
    output logic        din_sel,
    output logic        next_pc_sel,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        illegal
`ifdef SDLX_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state;
    state_t     state_nxt;
    iclass_t    cls_q;
    alu_op_t    alu_q;
    logic [2:0] dec_cls;
    logic [3:0] dec_alu;
    logic       dec_legal;
    logic       retire;
    logic       taken;

    // Register/shamt fields belong to the datapath; only opcode and funct steer control.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[25:6];

    sdlx_decode u_decode (
        .opcode (ir[31:26]),
        .funct  (ir[5:0]),
        .cls    (dec_cls),
        .alu_op (dec_alu),
        .legal  (dec_legal)
    );

    // State register plus decode class latched once per instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cls_q <= CLS_ALU_R;
            alu_q <= ALU_ADD;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                cls_q <= iclass_t'(dec_cls);
                alu_q <= alu_op_t'(dec_alu);
            end
        end
    end

    assign taken = (cls_q == CLS_J)
                || ((cls_q == CLS_BEQZ) && zero)
                || ((cls_q == CLS_BNEZ) && !zero);

    always_comb begin
        state_nxt    = state;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        rd_sel       = 1'b0;
        oprnd1_sel   = 1'b0;
        oprnd2_sel   = 1'b0;
        din_sel      = 1'b0;
        next_pc_sel  = 1'b0;
        alu_op       = ALU_ADD;
        busy         = (state != S_IDLE);
        illegal      = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = dec_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_op = alu_q;
                if (is_branch(cls_q)) begin
                    // Target is PC + imm of the branch itself; PC is not advanced until here.
                    oprnd2_sel  = 1'b1;
                    pc_we       = 1'b1;
                    next_pc_sel = !taken;
                    retire      = 1'b1;
                end else begin
                    oprnd1_sel = 1'b1;
                    oprnd2_sel = (cls_q != CLS_ALU_R);
                    state_nxt  = ((cls_q == CLS_LW) || (cls_q == CLS_SW)) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == CLS_SW);
                if (mem_ack) begin
                    if (cls_q == CLS_SW) begin
                        pc_we       = 1'b1;
                        next_pc_sel = 1'b1;
                        retire      = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we       = 1'b1;
                rd_sel      = (cls_q == CLS_ALU_R);
                din_sel     = (cls_q == CLS_LW);
                pc_we       = 1'b1;
                next_pc_sel = 1'b1;
                retire      = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (retire) state_nxt = run ? S_FETCH : S_IDLE;
    end

`ifdef SDLX_CTRL_PERF_EN
    // Free-running wrap-around counters of busy cycles and retired instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (busy)   cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdlx_control.sv
// Self-checking bench for sdlx_control: directed steps plus randomized instruction stream.
module tb_sdlx_control;

    logic        clk = 1'b0;
    logic        rst, run, zero, mem_ack;
    logic [31:0] ir;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, rd_sel;
    logic        oprnd1_sel, oprnd2_sel, din_sel, next_pc_sel, busy, illegal;
    logic [3:0]  alu_op;
    logic [31:0] cycle_cnt, instr_cnt;

    int          total = 0;
    int          bad   = 0;
    int unsigned model_cycles = 0;
    int unsigned model_instr  = 0;
    logic        running = 1'b0;

    localparam logic [16:0] REQ  = 17'h10000;
    localparam logic [16:0] WE   = 17'h08000;
    localparam logic [16:0] ASEL = 17'h04000;
    localparam logic [16:0] IRWE = 17'h02000;
    localparam logic [16:0] PCWE = 17'h01000;
    localparam logic [16:0] RFWE = 17'h00800;
    localparam logic [16:0] RDS  = 17'h00400;
    localparam logic [16:0] O1   = 17'h00200;
    localparam logic [16:0] O2   = 17'h00100;
    localparam logic [16:0] DINS = 17'h00080;
    localparam logic [16:0] NPS  = 17'h00040;
    localparam logic [16:0] BUSY = 17'h00002;
    localparam logic [16:0] ILL  = 17'h00001;

    logic [16:0] outv;
    assign outv = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, rd_sel,
                   oprnd1_sel, oprnd2_sel, din_sel, next_pc_sel, alu_op, busy, illegal};

    sdlx_control dut (
`ifdef SDLX_CTRL_PERF_EN
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt),
`endif
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .ir           (ir),
        .zero         (zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .rd_sel       (rd_sel),
        .oprnd1_sel   (oprnd1_sel),
        .oprnd2_sel   (oprnd2_sel),
        .din_sel      (din_sel),
        .next_pc_sel  (next_pc_sel),
        .alu_op       (alu_op),
        .busy         (busy),
        .illegal      (illegal)
    );

`ifndef SDLX_CTRL_PERF_EN
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction kind from the ISA tables: -1 illegal, 0 R, 1 I, 2 LW, 3 SW, 4 branch/jump.
    function automatic int klass(input logic [31:0] v);
        case (v[31:26])
            6'h00: begin
                case (v[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h2A: return 0;
                    default: return -1;
                endcase
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return 1;
            6'h23: return 2;
            6'h2B: return 3;
            6'h02, 6'h04, 6'h05: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input logic [31:0] v);
        if (v[31:26] == 6'h00) begin
            case (v[5:0])
                6'h20: return 4'd0;
                6'h22: return 4'd1;
                6'h24: return 4'd2;
                6'h25: return 4'd3;
                6'h26: return 4'd4;
                6'h04: return 4'd5;
                6'h06: return 4'd6;
                6'h2A: return 4'd7;
                default: return 4'd0;
            endcase
        end
        case (v[31:26])
            6'h0A: return 4'd7;
            6'h0C: return 4'd2;
            6'h0D: return 4'd3;
            6'h0E: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic is_taken(input logic [31:0] v, input logic z);
        if (v[31:26] == 6'h02) return 1'b1;
        if (v[31:26] == 6'h04) return z;
        return !z;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [5:0]  rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h2A};
        logic [5:0]  iop [10] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic [31:0] r;
        int          s;
        r = $urandom;
        s = $urandom_range(0, 19);
        if (s < 8) begin
            r[31:26] = 6'h00;
            r[5:0]   = rfn[$urandom_range(0, 7)];
        end else if (s < 18) begin
            r[31:26] = iop[$urandom_range(0, 9)];
        end else if (s == 18) begin
            r[31:26] = 6'h3F;
        end else begin
            r[31:26] = 6'h00;
            r[5:0]   = 6'h21;
        end
        return r;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the counter model, step the clock.
    task automatic cyc(input logic [16:0] ex, input string tag, input logic ack,
                       input logic z, input logic rn, input logic ret);
        mem_ack = ack;
        zero    = z;
        run     = rn;
        #2;
        total++;
        assert (outv === ex) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, outv, ex);
        end
        if (rst) begin
            model_cycles = 0;
            model_instr  = 0;
        end else begin
            if (ex[1]) model_cycles++;
            if (ret)   model_instr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; zero = 1'b0; ir = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cycles = 0;
        model_instr  = 0;
        running = 1'b0;
        cyc(17'h0, "reset_state", rb(), rb(), 1'b0, 1'b0);
    endtask

    task automatic do_instr(input logic [31:0] v, input int fw, input int mw, input logic z,
                            input logic run_after, input logic abort);
        int          k;
        int          n;
        logic [16:0] a;
        logic [16:0] memv;
        ir = v;
        k  = klass(v);
        a  = 17'(exp_alu(v)) << 2;
        if (!running) begin
            n = $urandom_range(0, 1);
            for (int i = 0; i < n; i++) cyc(17'h0, "idle", rb(), rb(), 1'b0, 1'b0);
            cyc(17'h0, "idle_start", rb(), rb(), 1'b1, 1'b0);
        end
        for (int i = 0; i < fw; i++) cyc(REQ | BUSY, "fetch_wait", 1'b0, rb(), rb(), 1'b0);
        cyc(REQ | IRWE | BUSY, "fetch_ack", 1'b1, rb(), rb(), 1'b0);
        cyc(BUSY, "decode", rb(), rb(), rb(), 1'b0);
        case (k)
            0: begin
                cyc(O1 | a | BUSY, "exec_r", rb(), rb(), rb(), 1'b0);
                cyc(RFWE | RDS | PCWE | NPS | BUSY, "wb_r", rb(), rb(), run_after, 1'b1);
            end
            1: begin
                cyc(O1 | O2 | a | BUSY, "exec_i", rb(), rb(), rb(), 1'b0);
                cyc(RFWE | PCWE | NPS | BUSY, "wb_i", rb(), rb(), run_after, 1'b1);
            end
            2, 3: begin
                cyc(O1 | O2 | BUSY, "exec_addr", rb(), rb(), rb(), 1'b0);
                memv = REQ | ASEL | BUSY | ((k == 3) ? WE : 17'h0);
                if (abort) begin
                    rst = 1'b1;
                    cyc(memv, "mem_abort", 1'b0, rb(), rb(), 1'b0);
                    rst = 1'b0;
                    running = 1'b0;
                    cyc(17'h0, "abort_idle", rb(), rb(), 1'b0, 1'b0);
                    return;
                end
                for (int i = 0; i < mw; i++) cyc(memv, "mem_wait", 1'b0, rb(), rb(), 1'b0);
                if (k == 2) begin
                    cyc(memv, "lw_ack", 1'b1, rb(), rb(), 1'b0);
                    cyc(RFWE | DINS | PCWE | NPS | BUSY, "wb_lw", rb(), rb(), run_after, 1'b1);
                end else begin
                    cyc(memv | PCWE | NPS, "sw_retire", 1'b1, rb(), run_after, 1'b1);
                end
            end
            4: begin
                cyc(O2 | PCWE | (is_taken(v, z) ? 17'h0 : NPS) | BUSY, "exec_br",
                    rb(), z, run_after, 1'b1);
            end
            default: begin
                n = $urandom_range(2, 4);
                for (int i = 0; i < n; i++) cyc(BUSY | ILL, "trap", rb(), rb(), rb(), 1'b0);
                rst = 1'b1;
                cyc(BUSY | ILL, "trap_rst", rb(), rb(), 1'b0, 1'b0);
                rst = 1'b0;
                running = 1'b0;
                cyc(17'h0, "trap_idle", rb(), rb(), 1'b0, 1'b0);
                return;
            end
        endcase
        running = run_after;
    endtask

    task automatic check_counters(input logic [31:0] exp_c, input logic [31:0] exp_i, input string tag);
`ifdef SDLX_CTRL_PERF_EN
        total++;
        assert (cycle_cnt === exp_c) else begin
            bad++;
            $error("FAIL %s_cycle_cnt: observed=%0d expected=%0d", tag, cycle_cnt, exp_c);
        end
        total++;
        assert (instr_cnt === exp_i) else begin
            bad++;
            $error("FAIL %s_instr_cnt: observed=%0d expected=%0d", tag, instr_cnt, exp_i);
        end
`else
        if (exp_c == 32'hFFFF_FFFF && exp_i == 32'hFFFF_FFFF) $display("%s", tag);
`endif
    endtask

    initial begin
        logic [31:0] v;
        logic        ra;
        do_reset();

        // Three back-to-back ADDs, run dropped at the third retire.
        do_instr(32'h00221820, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'h00221820, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 1'b0);
        check_counters(32'd12, 32'd3, "three_add");

        do_instr(32'h8C220004, 0, 2, 1'b0, 1'b0, 1'b0);
        do_instr(32'h10200005, 1, 0, 1'b1, 1'b1, 1'b0);
        do_instr(32'h10200005, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'h14200003, 0, 0, 1'b1, 1'b1, 1'b0);
        do_instr(32'h14200003, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'h08000010, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'h20220007, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'hFC000000, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(32'hAC220008, 0, 0, 1'b0, 1'b1, 1'b1);
        do_instr(32'hAC220008, 0, 1, 1'b0, 1'b1, 1'b0);
        do_instr(32'h00221822, 2, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 120; t++) begin
            v  = rand_ir();
            ra = ($urandom_range(0, 3) != 0);
            do_instr(v, $urandom_range(0, 2), $urandom_range(0, 2), rb(), ra,
                     ($urandom_range(0, 11) == 0));
        end
        check_counters(32'(model_cycles), 32'(model_instr), "random_perf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
